// File: rtl/fpa_timing_gen_if.sv
// fpa_timing_gen_if
//   Bundles the sequencer-side controls and the array/ADC-side timing outputs
//   of the FPA readout timing generator.
//   master modport: the system sequencer (drives config/trigger, observes timing).
//   slave modport : fpa_timing_gen itself.
//   Optional: FPA_TGEN_DECIM_EN adds the decim control (row decimation).
//   Signals: en, tc, cont, int_len, smp_len, [decim] -> generator
//            row, col, integ, sample, dr, f_sync, f_done, busy, row_idx, col_idx <- generator
interface fpa_timing_gen_if #(
    parameter int ROWS  = 240,
    parameter int COLS  = 320,
    parameter int INT_W = 16,
    parameter int SMP_W = 8
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic             en;
    logic             tc;
    logic             cont;
    logic [INT_W-1:0] int_len;
    logic [SMP_W-1:0] smp_len;
`ifdef FPA_TGEN_DECIM_EN
    logic             decim;
`endif
    logic [ROWS-1:0]  row;
    logic [COLS-1:0]  col;
    logic             integ;
    logic             sample;
    logic             dr;
    logic             f_sync;
    logic             f_done;
    logic             busy;
    logic [RW-1:0]    row_idx;
    logic [CW-1:0]    col_idx;

    modport master (
`ifdef FPA_TGEN_DECIM_EN
        output decim,
`endif
        output en, tc, cont, int_len, smp_len,
        input  row, col, integ, sample, dr, f_sync, f_done, busy, row_idx, col_idx
    );

    modport slave (
`ifdef FPA_TGEN_DECIM_EN
        input  decim,
`endif
        input  en, tc, cont, int_len, smp_len,
        output row, col, integ, sample, dr, f_sync, f_done, busy, row_idx, col_idx
    );
endinterface

// File: rtl/fpa_timing_gen.sv
// fpa_timing_gen
//   Run-time programmable focal-plane-array readout timing generator.
//   Per row: one-hot row select held for the whole row, an integration window,
//   a sample window, then a one-hot column scan with dr high. Frames start on
//   tc in IDLE; with cont latched high the next frame follows without a gap.
//   All flops update on the falling edge of clk; rst is async active-low.
//   Ports: clk, rst, bus (fpa_timing_gen_if.slave).
//   Optional: FPA_TGEN_DECIM_EN enables bus.decim (visit even rows only).
//
//   state  | meaning
//   IDLE   | no frame; all selects low, counters cleared
//   INTEG  | integration window for row row_idx
//   SAMPLE | sample/hold window for row row_idx
//   READ   | column scan, one column per cycle
module fpa_timing_gen #(
    parameter int ROWS  = 240,
    parameter int COLS  = 320,
    parameter int INT_W = 16,
    parameter int SMP_W = 8
) (
    input logic             clk,
    input logic             rst,
    fpa_timing_gen_if.slave bus
);
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int CNT_W = (INT_W > SMP_W) ? INT_W : SMP_W;

    typedef enum logic [1:0] {IDLE, INTEG, SAMPLE, READ} state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    row_idx_q, row_idx_d;
    logic [CW-1:0]    col_idx_q, col_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [INT_W-1:0] int_len_q, int_len_d;
    logic [SMP_W-1:0] smp_len_q, smp_len_d;
    logic             cont_q, cont_d;
    logic             f_sync_q, f_sync_d;
    logic             f_done_q, f_done_d;

    logic [CNT_W-1:0] new_int_m1;
    logic [CNT_W-1:0] lat_int_m1;
    logic [CNT_W-1:0] lat_smp_m1;
    logic [RW-1:0]    row_step;
    logic             last_row;
    logic             last_col;
    logic             start_frame;

    // Window counters load length-1 and end at zero, so a length of 0 behaves as 1.
    assign new_int_m1 = (bus.int_len == '0) ? '0 : CNT_W'(bus.int_len - INT_W'(1));
    assign lat_int_m1 = (int_len_q == '0) ? '0 : CNT_W'(int_len_q - INT_W'(1));
    assign lat_smp_m1 = (smp_len_q == '0) ? '0 : CNT_W'(smp_len_q - SMP_W'(1));
    assign last_col   = (col_idx_q == CW'(COLS - 1));

`ifdef FPA_TGEN_DECIM_EN
    localparam int LAST_DEC = (ROWS % 2 == 0) ? ROWS - 2 : ROWS - 1;
    logic decim_q, decim_d;
    assign row_step = decim_q ? RW'(2) : RW'(1);
    assign last_row = decim_q ? (row_idx_q == RW'(LAST_DEC)) : (row_idx_q == RW'(ROWS - 1));
`else
    assign row_step = RW'(1);
    assign last_row = (row_idx_q == RW'(ROWS - 1));
`endif

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        cnt_d       = cnt_q;
        int_len_d   = int_len_q;
        smp_len_d   = smp_len_q;
        cont_d      = cont_q;
        f_sync_d    = 1'b0;
        f_done_d    = 1'b0;
        start_frame = 1'b0;
`ifdef FPA_TGEN_DECIM_EN
        decim_d     = decim_q;
`endif
        if (!bus.en) begin
            state_d   = IDLE;
            row_idx_d = '0;
            col_idx_d = '0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    start_frame = bus.tc;
                end
                INTEG: begin
                    if (cnt_q == '0) begin
                        state_d = SAMPLE;
                        cnt_d   = lat_smp_m1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    if (cnt_q == '0) begin
                        state_d   = READ;
                        col_idx_d = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                READ: begin
                    if (last_col) begin
                        col_idx_d = '0;
                        if (last_row) begin
                            f_done_d  = 1'b1;
                            state_d   = IDLE;
                            row_idx_d = '0;
                            // Continuous mode chains straight into row 0 of the next frame.
                            start_frame = cont_q;
                        end else begin
                            row_idx_d = row_idx_q + row_step;
                            cnt_d     = lat_int_m1;
                            state_d   = INTEG;
                        end
                    end else begin
                        col_idx_d = col_idx_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
            if (start_frame) begin
                int_len_d = bus.int_len;
                smp_len_d = bus.smp_len;
                cont_d    = bus.cont;
`ifdef FPA_TGEN_DECIM_EN
                decim_d   = bus.decim;
`endif
                row_idx_d = '0;
                col_idx_d = '0;
                cnt_d     = new_int_m1;
                state_d   = INTEG;
                f_sync_d  = 1'b1;
            end
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            row_idx_q <= '0;
            col_idx_q <= '0;
            cnt_q     <= '0;
            int_len_q <= '0;
            smp_len_q <= '0;
            cont_q    <= 1'b0;
            f_sync_q  <= 1'b0;
            f_done_q  <= 1'b0;
`ifdef FPA_TGEN_DECIM_EN
            decim_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            col_idx_q <= col_idx_d;
            cnt_q     <= cnt_d;
            int_len_q <= int_len_d;
            smp_len_q <= smp_len_d;
            cont_q    <= cont_d;
            f_sync_q  <= f_sync_d;
            f_done_q  <= f_done_d;
`ifdef FPA_TGEN_DECIM_EN
            decim_q   <= decim_d;
`endif
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.row     = bus.busy ? ({{(ROWS-1){1'b0}}, 1'b1} << row_idx_q) : '0;
    assign bus.col     = (state_q == READ) ? ({{(COLS-1){1'b0}}, 1'b1} << col_idx_q) : '0;
    assign bus.integ   = (state_q == INTEG);
    assign bus.sample  = (state_q == SAMPLE);
    assign bus.dr      = (state_q == READ);
    assign bus.f_sync  = f_sync_q;
    assign bus.f_done  = f_done_q;
    assign bus.row_idx = row_idx_q;
    assign bus.col_idx = col_idx_q;
endmodule

// File: tb/tb_fpa_timing_gen.sv
module tb_fpa_timing_gen;
    localparam int ROWS = 4;
    localparam int COLS = 8;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    fpa_timing_gen_if #(.ROWS(ROWS), .COLS(COLS), .INT_W(16), .SMP_W(8)) bus ();

    fpa_timing_gen #(.ROWS(ROWS), .COLS(COLS), .INT_W(16), .SMP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packed observation: {row_idx[1:0], col_idx[2:0], row[3:0], col[7:0], integ, sample, dr, busy}
    function automatic logic [20:0] obs();
        return {bus.row_idx, bus.col_idx, bus.row, bus.col, bus.integ, bus.sample, bus.dr, bus.busy};
    endfunction

    // Expected packed outputs k cycles after the first INTEG cycle of a frame.
    function automatic logic [20:0] exp_frame(int k, int il, int sl, int step, int nrows);
        logic [20:0] v;
        int per;
        int r;
        int p;
        v   = '0;
        per = il + sl + COLS;
        if (k < 0 || k >= per * nrows) return v;
        r = k / per;
        p = k % per;
        v[20:19] = 2'(r * step);
        v[15:12] = 4'(1 << (r * step));
        if (p >= il + sl) begin
            v[18:16] = 3'(p - il - sl);
            v[11:4]  = 8'(1 << (p - il - sl));
            v[1]     = 1'b1;
        end
        v[3] = (p < il);
        v[2] = (p >= il) && (p < il + sl);
        v[0] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        n_vec++;
        if (obs() !== 21'd0 || bus.f_sync !== 1'b0 || bus.f_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init obs=%h f_sync=%b f_done=%b exp=0", obs(), bus.f_sync, bus.f_done);
        end
        rst = 1'b1;
        @(posedge clk);
        bus.int_len = 16'd3;
        bus.smp_len = 8'd2;
        bus.tc      = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(posedge clk);
            if (k == 0) bus.tc = 1'b0;
        end
        n_vec++;
        if (obs() !== exp_frame(6, 3, 2, 1, 4)) begin
            n_err++;
            $display("FAIL reset_pre_read obs=%h exp=%h", obs(), exp_frame(6, 3, 2, 1, 4));
        end
        #1 rst = 1'b0;
        #1;
        n_vec++;
        if (obs() !== 21'd0 || bus.f_sync !== 1'b0 || bus.f_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async obs=%h f_sync=%b f_done=%b exp=0", obs(), bus.f_sync, bus.f_done);
        end
        @(posedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            n_vec++;
            if (obs() !== 21'd0 || bus.f_sync !== 1'b0) begin
                n_err++;
                $display("FAIL reset_stay_idle k=%0d obs=%h exp=0", k, obs());
            end
        end
    endtask

    task automatic test_single_frame();
        bus.int_len = 16'd3;
        bus.smp_len = 8'd2;
        bus.cont    = 1'b0;
        bus.tc      = 1'b1;
        for (int k = 0; k < 58; k++) begin
            @(posedge clk);
            if (k == 0) bus.tc = 1'b0;
            n_vec++;
            if (obs() !== exp_frame(k, 3, 2, 1, 4)) begin
                n_err++;
                $display("FAIL single k=%0d obs=%h exp=%h", k, obs(), exp_frame(k, 3, 2, 1, 4));
            end
            n_vec++;
            if (bus.f_sync !== (k == 0) || bus.f_done !== (k == 52)) begin
                n_err++;
                $display("FAIL single_pulses k=%0d f_sync=%b f_done=%b exp=%b/%b",
                         k, bus.f_sync, bus.f_done, (k == 0), (k == 52));
            end
            // Mid-frame config changes must not take effect.
            if (k == 20) begin
                bus.int_len = 16'd9;
                bus.cont    = 1'b1;
            end
        end
        bus.int_len = 16'd3;
        bus.cont    = 1'b0;
    endtask

    task automatic test_zero_lengths();
        bus.int_len = 16'd0;
        bus.smp_len = 8'd0;
        bus.tc      = 1'b1;
        for (int k = 0; k < 44; k++) begin
            @(posedge clk);
            if (k == 0) bus.tc = 1'b0;
            n_vec++;
            if (obs() !== exp_frame(k, 1, 1, 1, 4) || bus.f_done !== (k == 40)) begin
                n_err++;
                $display("FAIL zero_len k=%0d obs=%h f_done=%b exp=%h/%b",
                         k, obs(), bus.f_done, exp_frame(k, 1, 1, 1, 4), (k == 40));
            end
        end
    endtask

    task automatic test_continuous();
        logic [20:0] e;
        logic        es;
        logic        ed;
        bus.int_len = 16'd2;
        bus.smp_len = 8'd1;
        bus.cont    = 1'b1;
        bus.tc      = 1'b1;
        for (int k = 0; k < 140; k++) begin
            @(posedge clk);
            if (k == 0) bus.tc = 1'b0;
            // cont is re-latched at the frame 2 start; clearing it now ends frame 3.
            if (k == 50) bus.cont = 1'b0;
            e  = (k < 132) ? exp_frame(k % 44, 2, 1, 1, 4) : 21'd0;
            es = (k == 0) || (k == 44) || (k == 88);
            ed = (k == 44) || (k == 88) || (k == 132);
            n_vec++;
            if (obs() !== e || bus.f_sync !== es || bus.f_done !== ed) begin
                n_err++;
                $display("FAIL continuous k=%0d obs=%h f_sync=%b f_done=%b exp=%h/%b/%b",
                         k, obs(), bus.f_sync, bus.f_done, e, es, ed);
            end
        end
    endtask

    task automatic test_abort();
        bus.int_len = 16'd3;
        bus.smp_len = 8'd2;
        bus.cont    = 1'b0;
        bus.tc      = 1'b1;
        for (int k = 0; k <= 36; k++) begin
            @(posedge clk);
            if (k == 0)  bus.tc = 1'b0;
            if (k == 10) bus.tc = 1'b1;
            if (k == 13) bus.tc = 1'b0;
            n_vec++;
            if (obs() !== exp_frame(k, 3, 2, 1, 4) || bus.f_sync !== (k == 0)) begin
                n_err++;
                $display("FAIL abort_pre k=%0d obs=%h f_sync=%b exp=%h", k, obs(), bus.f_sync,
                         exp_frame(k, 3, 2, 1, 4));
            end
        end
        n_vec++;
        if (bus.row_idx !== 2'd2 || bus.col_idx !== 3'd5) begin
            n_err++;
            $display("FAIL abort_point row_idx=%0d col_idx=%0d exp=2/5", bus.row_idx, bus.col_idx);
        end
        bus.en = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk);
            n_vec++;
            if (obs() !== 21'd0 || bus.f_done !== 1'b0 || bus.f_sync !== 1'b0) begin
                n_err++;
                $display("FAIL abort_idle j=%0d obs=%h f_done=%b exp=0", j, obs(), bus.f_done);
            end
        end
        bus.en = 1'b1;
    endtask

`ifdef FPA_TGEN_DECIM_EN
    task automatic test_decim();
        bus.int_len = 16'd3;
        bus.smp_len = 8'd2;
        bus.cont    = 1'b0;
        bus.decim   = 1'b1;
        bus.tc      = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            if (k == 0) bus.tc = 1'b0;
            n_vec++;
            if (obs() !== exp_frame(k, 3, 2, 2, 2) || bus.f_sync !== (k == 0) ||
                bus.f_done !== (k == 26)) begin
                n_err++;
                $display("FAIL decim k=%0d obs=%h f_sync=%b f_done=%b exp=%h", k, obs(),
                         bus.f_sync, bus.f_done, exp_frame(k, 3, 2, 2, 2));
            end
        end
        bus.decim = 1'b0;
    endtask
`endif

    initial begin
        rst         = 1'b0;
        bus.en      = 1'b1;
        bus.tc      = 1'b0;
        bus.cont    = 1'b0;
        bus.int_len = 16'd0;
        bus.smp_len = 8'd0;
`ifdef FPA_TGEN_DECIM_EN
        bus.decim   = 1'b0;
`endif
        test_reset();
        repeat (3) @(posedge clk);
        test_single_frame();
        repeat (3) @(posedge clk);
        test_zero_lengths();
        repeat (3) @(posedge clk);
        test_continuous();
        repeat (3) @(posedge clk);
        test_abort();
        repeat (3) @(posedge clk);
`ifdef FPA_TGEN_DECIM_EN
        test_decim();
        repeat (3) @(posedge clk);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
